// File: rtl/fetch_decode_unit.sv
// Instruction fetch/decode sequencer: drives the program-memory address,
// latches the instruction, splits it into fields and hands ALU/LDI work to
// the execution unit over valid/ready. Jumps, branches, NOPs and HALT are
// resolved locally.
module fetch_decode_unit #(
    parameter int unsigned             PC_WIDTH = 8,
    parameter logic [PC_WIDTH-1:0]     RESET_PC = '0
) (
    input  logic                clock,
    input  logic                rst_n,
    output logic [PC_WIDTH-1:0] pc_out,
    input  logic [31:0]         instr_in,
    input  logic                zero_flag,
    output logic                issue_valid,
    input  logic                issue_ready,
    output logic [3:0]          opcode,
    output logic [2:0]          dr,
    output logic [2:0]          sr1,
    output logic [2:0]          sr2,
    output logic [7:0]          imm8,
    output logic                halted
);

    typedef enum logic [2:0] {
        S_RESET,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_HALT
    } state_t;

    state_t              state_q,  state_d;
    logic [PC_WIDTH-1:0] pc_q,     pc_d;
    logic [31:0]         ir_q,     ir_d;
    logic [3:0]          opcode_q, opcode_d;
    logic [2:0]          dr_q,     dr_d;
    logic [2:0]          sr1_q,    sr1_d;
    logic [2:0]          sr2_q,    sr2_d;
    logic [7:0]          imm8_q,   imm8_d;
    logic                halted_q, halted_d;

    logic [PC_WIDTH-1:0] pc_inc;
    logic [PC_WIDTH-1:0] pc_target;
    logic [3:0]          ir_op;

    // Reserved instruction bits are latched but deliberately never decoded.
    logic unused_rsvd;
    assign unused_rsvd = ^{ir_q[27], ir_q[23], ir_q[19], ir_q[15:8]};

    assign ir_op     = ir_q[31:28];
    assign pc_inc    = pc_q + PC_WIDTH'(1);
    assign pc_target = PC_WIDTH'(ir_q[7:0]);

    // All outputs come straight from registers, so no input reaches an output combinationally.
    assign pc_out      = pc_q;
    assign issue_valid = (state_q == S_EXEC);
    assign opcode      = opcode_q;
    assign dr          = dr_q;
    assign sr1         = sr1_q;
    assign sr2         = sr2_q;
    assign imm8        = imm8_q;
    assign halted      = halted_q;

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_RESET;
            pc_q     <= RESET_PC;
            ir_q     <= '0;
            opcode_q <= '0;
            dr_q     <= '0;
            sr1_q    <= '0;
            sr2_q    <= '0;
            imm8_q   <= '0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            opcode_q <= opcode_d;
            dr_q     <= dr_d;
            sr1_q    <= sr1_d;
            sr2_q    <= sr2_d;
            imm8_q   <= imm8_d;
            halted_q <= halted_d;
        end
    end

    // Sequencer next-state, PC update and field decode.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        opcode_d = opcode_q;
        dr_d     = dr_q;
        sr1_d    = sr1_q;
        sr2_d    = sr2_q;
        imm8_d   = imm8_q;
        halted_d = halted_q;

        case (state_q)
            S_RESET: begin
                state_d = S_FETCH;
            end
            S_FETCH: begin
                ir_d    = instr_in;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                opcode_d = ir_q[31:28];
                dr_d     = ir_q[26:24];
                sr1_d    = ir_q[22:20];
                sr2_d    = ir_q[18:16];
                imm8_d   = ir_q[7:0];
                if (!ir_op[3] || ir_op == 4'hA) begin
                    state_d = S_EXEC;
                end else if (ir_op == 4'h8) begin
                    pc_d    = pc_target;
                    state_d = S_FETCH;
                end else if (ir_op == 4'h9) begin
                    pc_d    = zero_flag ? pc_target : pc_inc;
                    state_d = S_FETCH;
                end else if (ir_op == 4'hF) begin
                    halted_d = 1'b1;
                    state_d  = S_HALT;
                end else begin
                    pc_d    = pc_inc;
                    state_d = S_FETCH;
                end
            end
            S_EXEC: begin
                if (issue_ready) begin
                    pc_d    = pc_inc;
                    state_d = S_FETCH;
                end
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_RESET;
            end
        endcase
    end

endmodule

// File: tb/tb_fetch_decode_unit.sv
// Scoreboard bench for fetch_decode_unit: an instruction-level interpreter
// predicts every issued operation; a monitor compares on each acceptance.
module tb_fetch_decode_unit;

    logic        clock = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  pc_out;
    logic [31:0] instr_in;
    logic        zero_flag;
    logic        issue_valid;
    logic        issue_ready = 1'b0;
    logic [3:0]  opcode;
    logic [2:0]  dr, sr1, sr2;
    logic [7:0]  imm8;
    logic        halted;

    // Second instance for the reset-vector wrap case.
    logic        w_rst_n = 1'b0;
    logic [7:0]  w_pc;
    logic [31:0] w_instr;
    logic        w_valid;
    logic        w_ready = 1'b0;
    logic [3:0]  w_opcode;
    logic [2:0]  w_dr, w_sr1, w_sr2;
    logic [7:0]  w_imm8;
    logic        w_halted;

    logic [31:0] mem [0:255];
    logic        zf_tab [0:255];

    assign instr_in  = mem[pc_out];
    assign zero_flag = zf_tab[pc_out];
    assign w_instr   = mem[w_pc];

    always #5 clock = ~clock;

    fetch_decode_unit #(.PC_WIDTH(8), .RESET_PC(8'h00)) dut (
        .clock(clock), .rst_n(rst_n), .pc_out(pc_out), .instr_in(instr_in),
        .zero_flag(zero_flag), .issue_valid(issue_valid), .issue_ready(issue_ready),
        .opcode(opcode), .dr(dr), .sr1(sr1), .sr2(sr2), .imm8(imm8), .halted(halted)
    );

    fetch_decode_unit #(.PC_WIDTH(8), .RESET_PC(8'hFF)) dut_w (
        .clock(clock), .rst_n(w_rst_n), .pc_out(w_pc), .instr_in(w_instr),
        .zero_flag(1'b0), .issue_valid(w_valid), .issue_ready(w_ready),
        .opcode(w_opcode), .dr(w_dr), .sr1(w_sr1), .sr2(w_sr2), .imm8(w_imm8),
        .halted(w_halted)
    );

    typedef struct packed {
        logic [3:0] op;
        logic [2:0] dr;
        logic [2:0] sr1;
        logic [2:0] sr2;
        logic [7:0] imm;
        logic [7:0] pc;
    } iss_t;

    iss_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   accepts  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // Monitor: every accepted operation must be the next predicted one.
    always @(negedge clock) begin
        if (rst_n && issue_valid && issue_ready) begin
            accepts++;
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_issue actual=%h%h%h%h%h pc=%h expected=none",
                         opcode, dr, sr1, sr2, imm8, pc_out);
            end else begin
                iss_t e;
                e = sb.pop_front();
                chk("issue", 32'({opcode, dr, sr1, sr2, imm8, pc_out}), 32'(e));
            end
        end
    end

    // Instruction-level interpreter of the program in mem[].
    task automatic run_model(input logic [7:0] start, output bit hlt, output logic [7:0] hpc);
        logic [7:0]  pc;
        logic [31:0] ins;
        logic [3:0]  op;
        pc  = start;
        hlt = 0;
        hpc = '0;
        for (int unsigned step = 0; step < 300 && sb.size() < 25; step++) begin
            ins = mem[pc];
            op  = ins[31:28];
            if (op <= 4'd7 || op == 4'hA) begin
                sb.push_back('{op, ins[26:24], ins[22:20], ins[18:16], ins[7:0], pc});
                pc = pc + 8'd1;
            end else if (op == 4'h8) begin
                pc = ins[7:0];
            end else if (op == 4'h9) begin
                pc = zf_tab[pc] ? ins[7:0] : pc + 8'd1;
            end else if (op == 4'hF) begin
                hlt = 1;
                hpc = pc;
                return;
            end else begin
                pc = pc + 8'd1;
            end
        end
    endtask

    task automatic fill_nop();
        for (int a = 0; a < 256; a++) begin
            mem[a]    = 32'hB000_0000;
            zf_tab[a] = 1'b0;
        end
    endtask

    task automatic gen_prog();
        logic [31:0] w;
        int unsigned r;
        for (int a = 0; a < 256; a++) begin
            w = $urandom;
            r = $urandom_range(0, 99);
            if (r < 50)      w[31:28] = 4'($urandom_range(0, 7));
            else if (r < 58) w[31:28] = 4'hA;
            else if (r < 72) w[31:28] = 4'h8;
            else if (r < 86) w[31:28] = 4'h9;
            else if (r < 96) w[31:28] = 4'($urandom_range(11, 14));
            else             w[31:28] = 4'hF;
            mem[a]    = w;
            zf_tab[a] = 1'($urandom_range(0, 1));
        end
    endtask

    // Hold reset for three cycles, check reset values, release just after an edge.
    task automatic do_reset();
        issue_ready = 1'b0;
        rst_n = 1'b0;
        sb.delete();
        repeat (3) @(posedge clock);
        #1;
        chk("rst_pc", 32'(pc_out), 32'h0);
        chk("rst_valid", 32'(issue_valid), 32'h0);
        chk("rst_fields", 32'({opcode, dr, sr1, sr2, imm8, halted}), 32'h0);
        rst_n = 1'b1;
    endtask

    task automatic wait_valid(input string nm);
        int unsigned n;
        n = 0;
        while (!issue_valid && n < 20) begin
            @(posedge clock); #1;
            n++;
        end
        if (!issue_valid) chk({nm, "_timeout"}, 32'h0, 32'h1);
    endtask

    task automatic run_cf(input logic zf, input logic [7:0] last);
        logic [7:0] seq [$];
        int         acc0;
        bit         vseen;
        fill_nop();
        mem[1]     = 32'h8000_0010;
        mem[16]    = 32'h9000_0020;
        zf_tab[16] = zf;
        do_reset();
        issue_ready = 1'b1;
        acc0  = accepts;
        vseen = 0;
        seq.push_back(pc_out);
        for (int c = 0; c < 10; c++) begin
            @(posedge clock); #1;
            if (issue_valid) vseen = 1;
            if (pc_out != seq[$]) seq.push_back(pc_out);
        end
        while (seq.size() < 4) seq.push_back(8'hXX);
        chk("cf_pc_seq", 32'({seq[0], seq[1], seq[2], seq[3]}), {8'h00, 8'h01, 8'h10, last});
        chk("cf_no_issue", 32'(vseen), 32'h0);
        chk("cf_no_accept", 32'(accepts - acc0), 32'h0);
        issue_ready = 1'b0;
    endtask

    initial begin
        int         acc0;
        bit         hlt;
        logic [7:0] hpc;
        int unsigned n;

        // Reset then fetch/issue of add R1,R2,R0.
        fill_nop();
        mem[0] = 32'h0120_0000;
        do_reset();
        sb.push_back('{4'h0, 3'd1, 3'd2, 3'd0, 8'h00, 8'h00});
        acc0 = accepts;
        issue_ready = 1'b1;
        @(posedge clock); #1;
        chk("fetch_valid_c1", 32'(issue_valid), 32'h0);
        @(posedge clock); #1;
        chk("fetch_valid_c2", 32'(issue_valid), 32'h0);
        @(posedge clock); #1;
        chk("fetch_valid_c3", 32'(issue_valid), 32'h1);
        chk("fetch_fields", 32'({opcode, dr, sr1, sr2}), 32'({4'h0, 3'd1, 3'd2, 3'd0}));
        @(posedge clock); #1;
        chk("fetch_pc_after", 32'(pc_out), 32'h1);
        chk("fetch_accepts", 32'(accepts - acc0), 32'h1);
        issue_ready = 1'b0;

        // Backpressure: four cycles of ready low.
        fill_nop();
        mem[0] = 32'h3456_00C3;
        do_reset();
        sb.push_back('{4'h3, 3'd4, 3'd5, 3'd6, 8'hC3, 8'h00});
        acc0 = accepts;
        wait_valid("bp");
        for (int c = 0; c < 4; c++) begin
            chk("bp_valid", 32'(issue_valid), 32'h1);
            chk("bp_hold", 32'({opcode, dr, sr1, sr2, imm8, pc_out}),
                32'({4'h3, 3'd4, 3'd5, 3'd6, 8'hC3, 8'h00}));
            @(posedge clock); #1;
        end
        chk("bp_valid5", 32'(issue_valid), 32'h1);
        chk("bp_no_accept", 32'(accepts - acc0), 32'h0);
        issue_ready = 1'b1;
        @(posedge clock); #1;
        issue_ready = 1'b0;
        chk("bp_drop", 32'(issue_valid), 32'h0);
        chk("bp_pc", 32'(pc_out), 32'h1);
        chk("bp_once", 32'(accepts - acc0), 32'h1);

        // Control flow both ways through the branch.
        run_cf(1'b1, 8'h20);
        run_cf(1'b0, 8'h11);

        // Reset vector at the top of the address space wraps to zero.
        rst_n = 1'b0;
        fill_nop();
        mem[255] = 32'hC000_0000;
        mem[0]   = 32'hA300_00A5;
        w_rst_n  = 1'b0;
        @(posedge clock); #1;
        chk("wrap_rst_pc", 32'(w_pc), 32'hFF);
        w_rst_n = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        chk("wrap_pc_ff", 32'(w_pc), 32'hFF);
        @(posedge clock); #1;
        chk("wrap_pc_00", 32'(w_pc), 32'h00);
        repeat (3) @(posedge clock);
        #1;
        chk("wrap_valid", 32'(w_valid), 32'h1);
        chk("wrap_fields", 32'({w_opcode, w_dr, w_imm8}), 32'({4'hA, 3'd3, 8'hA5}));
        w_rst_n = 1'b0;

        // Halt at address 2.
        fill_nop();
        mem[2] = 32'hF000_0000;
        do_reset();
        n = 0;
        while (pc_out != 8'h02 && n < 20) begin
            @(posedge clock); #1;
            n++;
        end
        chk("halt_reach_pc2", 32'(pc_out), 32'h2);
        @(posedge clock); #1;
        chk("halt_not_yet", 32'(halted), 32'h0);
        @(posedge clock); #1;
        chk("halt_set", 32'(halted), 32'h1);
        acc0 = accepts;
        for (int c = 0; c < 20; c++) begin
            issue_ready = 1'($urandom_range(0, 1));
            @(posedge clock); #1;
            chk("halt_frozen", 32'({pc_out, issue_valid, halted}), 32'({8'h02, 1'b0, 1'b1}));
        end
        chk("halt_no_accept", 32'(accepts - acc0), 32'h0);
        issue_ready = 1'b0;

        // Reset while an operation is waiting in EXEC.
        fill_nop();
        mem[5] = 32'h8000_0033;
        mem[0] = 32'h8000_0005;
        mem[8'h33] = 32'h2701_0044;
        do_reset();
        acc0 = accepts;
        wait_valid("mid");
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_valid", 32'(issue_valid), 32'h0);
        chk("mid_pc", 32'(pc_out), 32'h0);
        @(posedge clock); #1;
        chk("mid_no_accept", 32'(accepts - acc0), 32'h0);

        // Random programs against the interpreter.
        for (int t = 0; t < 10; t++) begin
            gen_prog();
            do_reset();
            rst_n = 1'b0;
            run_model(8'h00, hlt, hpc);
            rst_n = 1'b1;
            n = 0;
            while (sb.size() != 0 && n < 4000) begin
                issue_ready = ($urandom_range(0, 3) != 0);
                @(posedge clock); #1;
                n++;
            end
            issue_ready = 1'b0;
            if (sb.size() != 0) chk("rand_drain_timeout", 32'(sb.size()), 32'h0);
            if (hlt) begin
                n = 0;
                while (!halted && n < 2000) begin
                    @(posedge clock); #1;
                    n++;
                end
                chk("rand_halt", 32'({halted, issue_valid, pc_out}), 32'({1'b1, 1'b0, hpc}));
            end
        end

        rst_n = 1'b0;
        @(posedge clock);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
